// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the millisecond timer arbiter:
//   CLK_FREQ_HZ_DEF  default system clock frequency
//   MS_W             width of a delay in milliseconds
//   state_e          engine FSM states
//   ticks_per_ms()   clk cycles per millisecond for a given clock frequency
//   safe_clog2()     $clog2 that never returns a zero width
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int CLK_FREQ_HZ_DEF = 27_000_000;
    localparam int MS_W            = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_e;

    function automatic int ticks_per_ms(input int clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

    // A one-tick millisecond would give $clog2() == 0; keep at least one bit.
    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/timer_rr_pick.sv
// -----------------------------------------------------------------------------
// timer_rr_pick
// Combinational round-robin selector: returns the first set request at or
// after the round-robin pointer, wrapping around NUM_REQ.
//   i_req     request vector (one bit per requester)
//   i_rr_ptr  index with the highest priority this cycle
//   o_valid   at least one request is set
//   o_owner   index of the selected request (0 when none)
// -----------------------------------------------------------------------------
module timer_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
    output logic                       o_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_owner
);

    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic int wrap_idx(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum;
    endfunction

    logic [IDX_W-1:0] w_idx;

    // Walk from the farthest offset down to offset 0 so the closest match to
    // the pointer is the one left standing.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch; a path that leaves one unassigned infers a latch.
        o_valid = 1'b0;
        o_owner = '0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = IDX_W'(wrap_idx(int'(i_rr_ptr), k));
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_owner = w_idx;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
// Shares one millisecond countdown engine between NUM_REQ requesters. Each
// requester posts a delay in ms, the request is queued, granted round-robin,
// counted down, and answered with a one-cycle done pulse plus an optional
// latched interrupt.
//   clk, rst_n    system clock, asynchronous active-low reset
//   req_start     per-requester start pulse; req_ms slice sampled with it
//   req_ms        NUM_REQ x 16-bit delays in ms
//   req_cancel    withdraw a pending or running request
//   irq_en        per-requester interrupt enable (sampled in FINISH)
//   irq_ack       clear the matching irq_pending bit
//   req_pending   queued, not yet granted
//   req_active    one-hot owner of the engine, 0 when idle
//   req_done      one-cycle completion pulse
//   irq_pending   latched interrupt per requester
//   irq           OR of irq_pending
// -----------------------------------------------------------------------------
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_start,
    input  logic [NUM_REQ*MS_W-1:0] req_ms,
    input  logic [NUM_REQ-1:0]      req_cancel,
    input  logic [NUM_REQ-1:0]      irq_en,
    input  logic [NUM_REQ-1:0]      irq_ack,
    output logic [NUM_REQ-1:0]      req_pending,
    output logic [NUM_REQ-1:0]      req_active,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      irq_pending,
    output logic                    irq
);

    localparam int TICKS_PER_MS = ticks_per_ms(CLK_FREQ_HZ);
    localparam int PRE_W        = safe_clog2(TICKS_PER_MS);
    localparam int IDX_W        = $clog2(NUM_REQ);

    localparam logic [PRE_W-1:0]   PRE_MAX  = PRE_W'(TICKS_PER_MS - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [MS_W-1:0]    MS_ONE   = MS_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [MS_W-1:0]    r_counter;
    logic [PRE_W-1:0]   r_prescaler;
    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_active;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_irq_pending;
    logic [MS_W-1:0]    r_ms_lat [NUM_REQ];

    // -------------------------------------------------------------------------
    // Next-state wires
    // -------------------------------------------------------------------------
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [IDX_W-1:0]   w_rr_ptr_nxt;
    logic [MS_W-1:0]    w_counter_nxt;
    logic [PRE_W-1:0]   w_prescaler_nxt;
    logic [NUM_REQ-1:0] w_active_nxt;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic [NUM_REQ-1:0] w_grant_clr;
    logic [NUM_REQ-1:0] w_irq_set;
    logic [NUM_REQ-1:0] w_pending_nxt;
    logic [NUM_REQ-1:0] w_irq_pending_nxt;

    logic [NUM_REQ-1:0] w_accept;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic [IDX_W-1:0]   w_rr_after_owner;
    logic [MS_W-1:0]    w_owner_ms;
    logic               w_owner_cancel;

    logic [NUM_REQ-1:0] w_pick_req;
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;

    // A start is taken only from an idle requester; a cancel in the same
    // cycle suppresses it.
    assign w_accept         = req_start & ~r_pending & ~r_active & ~req_cancel;
    assign w_owner_oh       = ONE_HOT0 << r_owner;
    assign w_rr_after_owner = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
    assign w_owner_ms       = r_ms_lat[r_owner];
    assign w_owner_cancel   = req_cancel[r_owner];

    // A request being cancelled this cycle is not eligible for the grant.
    assign w_pick_req = r_pending & ~req_cancel;

    timer_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req    (w_pick_req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_owner  (w_pick_idx)
    );

    // -------------------------------------------------------------------------
    // Engine FSM: next state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_counter_nxt   = r_counter;
        w_prescaler_nxt = r_prescaler;
        w_active_nxt    = r_active;
        w_done_nxt      = '0;
        w_grant_clr     = '0;
        w_irq_set       = '0;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_owner_nxt  = w_pick_idx;
                    w_active_nxt = ONE_HOT0 << w_pick_idx;
                    w_grant_clr  = ONE_HOT0 << w_pick_idx;
                    w_state_nxt  = LOAD;
                end
            end

            LOAD: begin
                if (w_owner_cancel) begin
                    w_active_nxt = '0;
                    w_rr_ptr_nxt = w_rr_after_owner;
                    w_state_nxt  = IDLE;
                end else begin
                    w_counter_nxt   = w_owner_ms;
                    w_prescaler_nxt = '0;
                    if (w_owner_ms == '0) begin
                        w_done_nxt  = w_owner_oh;
                        w_state_nxt = FINISH;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end

            RUN: begin
                if (w_owner_cancel) begin
                    w_active_nxt = '0;
                    w_rr_ptr_nxt = w_rr_after_owner;
                    w_state_nxt  = IDLE;
                end else if (r_prescaler == PRE_MAX) begin
                    // One millisecond elapsed; the counter is never 0 here
                    // because LOAD routes a zero delay straight to FINISH.
                    w_prescaler_nxt = '0;
                    w_counter_nxt   = r_counter - MS_ONE;
                    if (r_counter == MS_ONE) begin
                        w_done_nxt  = w_owner_oh;
                        w_state_nxt = FINISH;
                    end
                end else begin
                    w_prescaler_nxt = r_prescaler + 1'b1;
                end
            end

            FINISH: begin
                // Cancel is ignored here: completion is already committed.
                w_irq_set    = irq_en[r_owner] ? w_owner_oh : '0;
                w_rr_ptr_nxt = w_rr_after_owner;
                w_active_nxt = '0;
                w_state_nxt  = IDLE;
            end

            default: begin
                w_active_nxt = '0;
                w_state_nxt  = IDLE;
            end
        endcase
    end

    assign w_pending_nxt     = (r_pending | w_accept) & ~req_cancel & ~w_grant_clr;
    // A completion in the same cycle as an acknowledge keeps the interrupt.
    assign w_irq_pending_nxt = (r_irq_pending & ~irq_ack) | w_irq_set;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_counter     <= '0;
            r_prescaler   <= '0;
            r_pending     <= '0;
            r_active      <= '0;
            r_done        <= '0;
            r_irq_pending <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_counter     <= w_counter_nxt;
            r_prescaler   <= w_prescaler_nxt;
            r_pending     <= w_pending_nxt;
            r_active      <= w_active_nxt;
            r_done        <= w_done_nxt;
            r_irq_pending <= w_irq_pending_nxt;
        end
    end

    // NOTE: the delay latches are a small register array, not a RAM, and must
    // read as 0 after reset, so they sit on the async reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_ms_lat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_ms_lat[i] <= req_ms[MS_W*i +: MS_W];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_pending = r_pending;
    assign req_active  = r_active;
    assign req_done    = r_done;
    assign irq_pending = r_irq_pending;
    assign irq         = |r_irq_pending;

endmodule

// File: tb/tb_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timer_arbiter
// Self-checking bench for timer_arbiter with NUM_REQ=4 and a 4 kHz clock
// (4 ticks per ms). A deadline-based reference model predicts every output
// each cycle; directed scenarios add hand-computed edge counts and states.
// -----------------------------------------------------------------------------
module tb_timer_arbiter;

    localparam int N    = 4;
    localparam int T    = 4;
    localparam int FREQ = 4000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_start;
    logic [N*16-1:0] req_ms;
    logic [N-1:0]    req_cancel;
    logic [N-1:0]    irq_en;
    logic [N-1:0]    irq_ack;
    logic [N-1:0]    req_pending;
    logic [N-1:0]    req_active;
    logic [N-1:0]    req_done;
    logic [N-1:0]    irq_pending;
    logic            irq;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    timer_arbiter #(
        .NUM_REQ     (N),
        .CLK_FREQ_HZ (FREQ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_start   (req_start),
        .req_ms      (req_ms),
        .req_cancel  (req_cancel),
        .irq_en      (irq_en),
        .irq_ack     (irq_ack),
        .req_pending (req_pending),
        .req_active  (req_active),
        .req_done    (req_done),
        .irq_pending (irq_pending),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: the running job is described by its owner and the edge
    // at which its done pulse must appear (grant edge + 1 + ms*T).
    // -------------------------------------------------------------------------
    bit          m_busy;
    logic [1:0]  m_own;
    logic [1:0]  m_rr;
    int          m_d;
    logic [N-1:0] m_pend, m_irq, m_done;
    logic [15:0] m_ms [N];
    logic [N-1:0] mp, ma, macc, mgclr, mset, mdone;
    logic [1:0]  cand;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_own = '0; m_rr = '0; m_d = 0;
            m_pend = '0; m_irq = '0; m_done = '0;
            for (int i = 0; i < N; i++) m_ms[i] = '0;
        end else begin
            edge_cnt++;
            mp    = m_pend;
            ma    = m_busy ? (4'b0001 << m_own) : 4'b0000;
            mgclr = '0; mset = '0; mdone = '0;
            if (m_busy) begin
                if (edge_cnt == m_d + 1) begin
                    if (irq_en[m_own]) mset = ma;
                    m_rr = m_own + 2'd1;
                    m_busy = 1'b0;
                end else if (req_cancel[m_own]) begin
                    m_rr = m_own + 2'd1;
                    m_busy = 1'b0;
                end else if (edge_cnt == m_d) begin
                    mdone = ma;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    cand = m_rr + 2'(k);
                    if (!m_busy && mp[cand] && !req_cancel[cand]) begin
                        m_busy = 1'b1;
                        m_own  = cand;
                        m_d    = edge_cnt + 1 + int'(m_ms[cand]) * T;
                        mgclr  = 4'b0001 << cand;
                    end
                end
            end
            macc = req_start & ~mp & ~ma & ~req_cancel;
            for (int i = 0; i < N; i++) if (macc[i]) m_ms[i] = req_ms[16*i +: 16];
            m_pend = (mp | macc) & ~req_cancel & ~mgclr;
            m_irq  = (m_irq & ~irq_ack) | mset;
            m_done = mdone;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("model_pending", 32'(req_pending), 32'(m_pend));
            check("model_active",  32'(req_active),  m_busy ? 32'(4'b0001 << m_own) : 32'd0);
            check("model_done",    32'(req_done),    32'(m_done));
            check("model_irq_pending", 32'(irq_pending), 32'(m_irq));
            check("model_irq",     32'(irq),         32'(|m_irq));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic set_ms(input int ch, input logic [15:0] val);
        req_ms[16*ch +: 16] = val;
    endtask

    // Drive a start pulse; e0 is the edge that samples it.
    task automatic pulse(input logic [N-1:0] mask, output int e0);
        req_start = mask;
        e0 = edge_cnt + 1;
        @(negedge clk);
        req_start = '0;
    endtask

    task automatic wait_done(input int ch, input int e0, input int exp_rel, input string name);
        int rel;
        rel = -1;
        for (int i = 0; i < 60 && rel < 0; i++) begin
            @(negedge clk);
            if (req_done[ch]) rel = edge_cnt - e0;
        end
        check(name, 32'(rel), 32'(exp_rel));
    endtask

    task automatic ack(input logic [N-1:0] mask);
        irq_ack = mask;
        @(negedge clk);
        irq_ack = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, e1, done_seen;
        rst_n = 1'b0; req_start = '0; req_ms = '0; req_cancel = '0;
        irq_en = '0; irq_ack = '0;
        repeat (2) @(negedge clk);
        check("reset_pending", 32'(req_pending), 32'd0);
        check("reset_active",  32'(req_active),  32'd0);
        check("reset_done",    32'(req_done),    32'd0);
        check("reset_irq",     32'(irq),         32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request ch0, 3 ms, interrupt enabled.
        irq_en = 4'b0001;
        set_ms(0, 16'd3);
        pulse(4'b0001, e0);
        wait_done(0, e0, 14, "single_done_edge");
        @(negedge clk);
        check("single_irq_pending", 32'(irq_pending), 32'h1);
        check("single_irq",         32'(irq),         32'h1);
        ack(4'b0001);
        check("single_irq_ack",     32'(irq_pending), 32'h0);
        irq_en = '0;

        // Simultaneous starts from reset.
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        set_ms(0, 16'd1); set_ms(2, 16'd2); set_ms(3, 16'd1);
        pulse(4'b1101, e0);
        wait_done(0, e0, 6, "multi_done0_edge");
        check("multi_active0", 32'(req_active), 32'b0001);
        wait_done(2, e0, 17, "multi_done2_edge");
        check("multi_active2", 32'(req_active), 32'b0100);
        wait_done(3, e0, 24, "multi_done3_edge");
        check("multi_active3", 32'(req_active), 32'b1000);
        @(negedge clk);

        // Fairness: ch1 running, ch0 and ch2 queue behind it.
        set_ms(1, 16'd1);
        pulse(4'b0010, e0);
        repeat (3) @(negedge clk);
        set_ms(0, 16'd1); set_ms(2, 16'd1);
        pulse(4'b0101, e1);
        wait_done(1, e0, 6, "fair_done1_edge");
        wait_done(2, e0, 13, "fair_done2_edge");
        check("fair_ch0_still_pending", 32'(req_pending), 32'b0001);
        wait_done(0, e0, 20, "fair_done0_edge");
        // Start during FINISH of the same channel is ignored.
        set_ms(0, 16'd2);
        pulse(4'b0001, e1);
        check("finish_start_ignored", 32'(req_pending), 32'd0);
        // Pointer now at 1: ch1 wins over ch0.
        set_ms(0, 16'd0); set_ms(1, 16'd0);
        pulse(4'b0011, e1);
        @(negedge clk);
        check("rr_ptr_after_ch0", 32'(req_active), 32'b0010);
        wait_done(0, e1, 5, "rr_done0_edge");
        @(negedge clk);

        // Cancel of the active owner in RUN cycle 7.
        irq_en = 4'b1111;
        set_ms(1, 16'd5); set_ms(2, 16'd1);
        pulse(4'b0110, e0);
        repeat (8) @(negedge clk);
        req_cancel = 4'b0010;
        @(negedge clk);
        req_cancel = '0;
        check("cancel_engine_idle", 32'(req_active), 32'd0);
        check("cancel_no_done",     32'(req_done),   32'd0);
        @(negedge clk);
        check("cancel_ch2_granted", 32'(req_active), 32'b0100);
        wait_done(2, e0, 15, "cancel_done2_edge");
        @(negedge clk);
        check("cancel_irq_only_ch2", 32'(irq_pending), 32'b0100);
        ack(4'b1111);

        // Zero delay.
        set_ms(0, 16'd0);
        pulse(4'b0001, e0);
        wait_done(0, e0, 2, "zero_done_edge");
        @(negedge clk);
        check("zero_irq_pending", 32'(irq_pending), 32'b0001);
        ack(4'b1111);

        // Reset in the middle of RUN with ch3 queued.
        set_ms(1, 16'd2); set_ms(3, 16'd1);
        pulse(4'b1010, e0);
        repeat (4) @(negedge clk);
        check("pre_reset_ch3_pending", 32'(req_pending), 32'b1000);
        #1 rst_n = 1'b0;
        #1;
        check("rst_pending",     32'(req_pending), 32'd0);
        check("rst_active",      32'(req_active),  32'd0);
        check("rst_done",        32'(req_done),    32'd0);
        check("rst_irq_pending", 32'(irq_pending), 32'd0);
        check("rst_irq",         32'(irq),         32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (|req_done) done_seen++;
        end
        check("post_reset_no_done",    32'(done_seen),   32'd0);
        check("post_reset_no_pending", 32'(req_pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
